wvl_lag_latch_capture: RTL
==========================

WVL_LAG_LATCH_CAPTURE -- requirements
Module: wvl_lag_latch_capture

Interface
REQ-001 SHALL have parameter TS_W, default 16, timestamp and lag width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, timestamp FIFO depth; power of two.
REQ-003 SHALL have port user_clk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port user_rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port user_data_in  in  32  software latch register word: bit0 latch request, bit1 clear stats, [31:16] lag threshold.
REQ-006 SHALL have port stage_in_vld  in  1  photon entering the monitored pipeline stage.
REQ-007 SHALL have port stage_out_vld  in  1  photon leaving the monitored stage, in order.
REQ-008 SHALL have port lag_last_latched  out  TS_W  latched lag of the most recent pop.
REQ-009 SHALL have port lag_max_latched  out  TS_W  latched maximum lag since the last clear.
REQ-010 SHALL have port lag_min_latched  out  TS_W  latched minimum lag since the last clear (see Configuration).
REQ-011 SHALL have port over_cnt_latched  out  16  latched count of pops with lag > threshold.
REQ-012 SHALL have port inflight_latched  out  log2(DEPTH)+1  latched FIFO occupancy.
REQ-013 SHALL have port err_latched  out  2  latched sticky flags {overflow, underflow}.
REQ-014 SHALL have port latch_done  out  1  one-cycle pulse when latched outputs update.

Function
REQ-015 SHALL run a free-running TS_W-bit cycle counter that wraps modulo 2^TS_W.
REQ-016 SHALL push the current counter value into the FIFO on stage_in_vld.
REQ-017 SHALL pop the head on stage_out_vld and compute lag = counter - head, modulo 2^TS_W.
REQ-018 SHALL treat lags of 2^TS_W cycles or more as aliased; no detection is required.
REQ-019 SHALL update live lag_last and lag_max every pop, plus lag_min when compiled in.
REQ-020 SHALL increment live over_cnt when lag > user_data_in[31:16] (strict), saturating at 0xFFFF.
REQ-021 SHALL, on push and pop in the same cycle, perform both with occupancy unchanged, including when full.
REQ-022 SHALL, on push when full without pop, drop the push and set sticky overflow.
REQ-023 SHALL, on pop when empty, ignore the pop, set sticky underflow, and still perform any coincident push.
REQ-024 SHALL detect the latch request as bit0 high in cycle N with bit0 low in cycle N-1.
REQ-025 SHALL update all *_latched outputs from live values at N+1 and pulse latch_done at N+1 only.
REQ-026 SHALL, on a bit1 rising edge, clear live lag_max to 0, lag_min to all-ones, over_cnt to 0 and sticky error flags, effective next cycle.
REQ-027 SHALL leave FIFO contents, occupancy and the cycle counter unaffected by a clear.
REQ-028 SHALL, on a latch edge and a clear edge in the same cycle, latch the pre-clear values.
REQ-029 SHALL give a pop in the latch-detect cycle priority so that the pop is included in the latched values.

Reset
REQ-030 SHALL, on user_rst_n low, immediately zero the counter, FIFO pointers, occupancy, live stats, all *_latched outputs and latch_done.
REQ-031 SHALL reset lag_min_latched and live lag_min to all-ones.
REQ-032 SHALL reset the bit0 and bit1 edge-detect history registers to 1 so that a request held high through reset release does not trigger.
REQ-033 SHALL discard in-flight timestamps when reset is asserted mid-operation.

Configuration
REQ-034 SHALL, with WVL_LAG_MIN_EN defined, track minimum lag per REQ-019 and REQ-026.
REQ-035 SHALL, without WVL_LAG_MIN_EN, drive lag_min_latched constant all-ones with no minimum-tracking logic.

Verification
REQ-036 SHALL cover: push at count 10, pop at count 25, latch -> lag_last=15, lag_max=15, inflight=0, latch_done one cycle.
REQ-037 SHALL cover: threshold 20, lags 15/21/20/30 -> over_cnt=2, lag_max=30, lag_min=15 (macro on) or 0xFFFF (macro off).
REQ-038 SHALL cover: 17 pushes with no pops -> inflight=16, err=2'b10; then pop while empty -> err=2'b11.
REQ-039 SHALL cover: push at count 0xFFF0, pop at count 0x0005 -> lag_last=0x0015.
REQ-040 SHALL cover: latch and clear edges in the same cycle -> pre-clear values latched; next latch -> lag_max=0, over_cnt=0.
REQ-041 SHALL cover: bit0 held high across reset release -> no latch_done until bit0 goes low then high.

Source files
------------

// File: rtl/wvl_lag_latch_capture_if.sv
// Purpose: bundles the latch-register word, stage strobes and latched results of the lag monitor.
// Latency: none, wiring only.
// Backpressure: none; strobes are fire-and-forget, results hold until the next latch.
interface wvl_lag_latch_capture_if #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 16
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [31:0]      user_data_in;
  logic             stage_in_vld;
  logic             stage_out_vld;
  logic [TS_W-1:0]  lag_last_latched;
  logic [TS_W-1:0]  lag_max_latched;
  logic [TS_W-1:0]  lag_min_latched;
  logic [15:0]      over_cnt_latched;
  logic [OCC_W-1:0] inflight_latched;
  logic [1:0]       err_latched;
  logic             latch_done;

  // Software / stimulus side.
  modport master (
    output user_data_in, stage_in_vld, stage_out_vld,
    input  lag_last_latched, lag_max_latched, lag_min_latched,
           over_cnt_latched, inflight_latched, err_latched, latch_done
  );

  // Monitor side.
  modport slave (
    input  user_data_in, stage_in_vld, stage_out_vld,
    output lag_last_latched, lag_max_latched, lag_min_latched,
           over_cnt_latched, inflight_latched, err_latched, latch_done
  );
endinterface

// File: rtl/wvl_lag_latch_capture.sv
// Purpose: timestamps photons entering a stage, measures in-order exit lag, keeps stats, latches them on request.
// Latency: latched outputs and latch_done appear one cycle after the bit0 rising edge (pop of that cycle included).
// Backpressure: none; push when full is dropped (sticky overflow), pop when empty is ignored (sticky underflow).
// Optional minimum-lag tracking is compiled in with `define WVL_LAG_MIN_EN.
module wvl_lag_latch_capture #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 16
) (
  input  logic                     user_clk,
  input  logic                     user_rst_n,
  wvl_lag_latch_capture_if.slave   bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [TS_W-1:0]  cnt;
  logic [TS_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ, occ_nxt;
  logic             lat_hist, clr_hist;
  logic             lat_edge, clr_edge;
  logic             full, empty, push_ok, pop_ok, ovf, udf;
  logic [TS_W-1:0]  thr, lag;

  logic [TS_W-1:0]  lag_last, lag_max;
  logic [15:0]      over_cnt;
  logic [1:0]       err;
  logic [TS_W-1:0]  upd_last, upd_max;
  logic [15:0]      upd_over;
  logic [1:0]       upd_err;

  // FIFO control, lag arithmetic, edge detects and the pre-clear stats update.
  always_comb begin
    full     = (occ == FULL_OCC);
    empty    = (occ == '0);
    pop_ok   = bus.stage_out_vld && !empty;
    // A pop frees the slot, so push+pop while full still succeeds.
    push_ok  = bus.stage_in_vld && (!full || pop_ok);
    ovf      = bus.stage_in_vld && full && !pop_ok;
    udf      = bus.stage_out_vld && empty;
    lag      = cnt - mem[rd_ptr];
    thr      = TS_W'(bus.user_data_in[31:16]);
    lat_edge = bus.user_data_in[0] && !lat_hist;
    clr_edge = bus.user_data_in[1] && !clr_hist;

    occ_nxt = occ;
    if (push_ok && !pop_ok)      occ_nxt = occ + 1'b1;
    else if (pop_ok && !push_ok) occ_nxt = occ - 1'b1;

    upd_last = lag_last;
    upd_max  = lag_max;
    upd_over = over_cnt;
    upd_err  = err | {ovf, udf};
    if (pop_ok) begin
      upd_last = lag;
      if (lag > lag_max) upd_max = lag;
      if ((lag > thr) && (over_cnt != 16'hFFFF)) upd_over = over_cnt + 16'd1;
    end
  end

  // Timestamp storage; contents need no reset because the pointers define validity.
  always_ff @(posedge user_clk) begin
    if (push_ok) mem[wr_ptr] <= cnt;
  end

  // Free-running counter, FIFO pointers/occupancy and request-edge history.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      lat_hist <= 1'b1;
      clr_hist <= 1'b1;
    end else begin
      cnt      <= cnt + 1'b1;
      occ      <= occ_nxt;
      lat_hist <= bus.user_data_in[0];
      clr_hist <= bus.user_data_in[1];
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Live statistics; a clear edge overrides the update for the clearable fields.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      lag_last <= '0;
      lag_max  <= '0;
      over_cnt <= '0;
      err      <= '0;
    end else begin
      lag_last <= upd_last;
      if (clr_edge) begin
        lag_max  <= '0;
        over_cnt <= '0;
        err      <= '0;
      end else begin
        lag_max  <= upd_max;
        over_cnt <= upd_over;
        err      <= upd_err;
      end
    end
  end

  // Snapshot the pre-clear, post-pop values on a latch edge and pulse latch_done.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      bus.lag_last_latched <= '0;
      bus.lag_max_latched  <= '0;
      bus.over_cnt_latched <= '0;
      bus.inflight_latched <= '0;
      bus.err_latched      <= '0;
      bus.latch_done       <= 1'b0;
    end else begin
      bus.latch_done <= lat_edge;
      if (lat_edge) begin
        bus.lag_last_latched <= upd_last;
        bus.lag_max_latched  <= upd_max;
        bus.over_cnt_latched <= upd_over;
        bus.inflight_latched <= occ_nxt;
        bus.err_latched      <= upd_err;
      end
    end
  end

`ifdef WVL_LAG_MIN_EN
  logic [TS_W-1:0] lag_min, upd_min;

  // Minimum lag candidate including this cycle's pop.
  always_comb begin
    upd_min = lag_min;
    if (pop_ok && (lag < lag_min)) upd_min = lag;
  end

  // Live and latched minimum; all-ones means no pop seen since the last clear.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      lag_min             <= '1;
      bus.lag_min_latched <= '1;
    end else begin
      lag_min <= clr_edge ? '1 : upd_min;
      if (lat_edge) bus.lag_min_latched <= upd_min;
    end
  end
`else
  assign bus.lag_min_latched = '1;
`endif

endmodule
